// File: rtl/ecs_scheduler.sv
// Row scheduler for the three JPEG component encoders: grants Y, Cb, Cr in turn per MCU,
// forwards the granted encoder's words to the bit packer and flags protocol errors.
`timescale 1ns/1ps
module ecs_scheduler #(
    parameter int GAP_CYCLES = 8,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        row_start,
    input  logic [7:0]  h_mcu,
    output logic [2:0]  ce_req,
    output logic [7:0]  ce_x_mcu,
    input  logic [17:0] ce_len,
    input  logic [95:0] ce_data,
    input  logic [2:0]  ce_last,
    output logic [5:0]  out_len,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        row_done,
    input  logic        err_clr,
    output logic [2:0]  err
);

    localparam int CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, REQ_Y, REQ_CB, REQ_CR, GAP, DONE} state_t;

    // With no gap configured the row ends straight into DONE.
    localparam state_t ROW_END = (GAP_CYCLES == 0) ? DONE : GAP;

    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d;
    logic [7:0]        h_q, h_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        ce_req_q;
    logic              busy_q;
    logic              row_done_q;
    logic [5:0]        out_len_q;
    logic [31:0]       out_data_q;
    logic [2:0]        err_q;

    logic [2:0]        has_word;
    logic              granted_last;
    logic              in_req;
    logic              coll_evt, ovr_evt, tmo_evt;
    logic [5:0]        sel_len;
    logic [31:0]       sel_data;

    function automatic logic [2:0] req_onehot(input state_t s);
        case (s)
            REQ_Y:   return 3'b001;
            REQ_CB:  return 3'b010;
            REQ_CR:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    assign has_word     = {|ce_len[17:12], |ce_len[11:6], |ce_len[5:0]};
    assign granted_last = |(ce_last & ce_req_q);
    assign in_req       = (state_q == REQ_Y) || (state_q == REQ_CB) || (state_q == REQ_CR);
    assign coll_evt     = |((has_word | ce_last) & ~ce_req_q);
    assign ovr_evt      = row_start && (state_q != IDLE);
    assign tmo_evt      = in_req && !granted_last && (cnt_q == TMO_LAST);

    // Only the granted encoder's non-empty word reaches the packer.
    always_comb begin
        sel_len  = '0;
        sel_data = '0;
        if (ce_req_q[0] && has_word[0]) begin
            sel_len  = ce_len[5:0];
            sel_data = ce_data[31:0];
        end else if (ce_req_q[1] && has_word[1]) begin
            sel_len  = ce_len[11:6];
            sel_data = ce_data[63:32];
        end else if (ce_req_q[2] && has_word[2]) begin
            sel_len  = ce_len[17:12];
            sel_data = ce_data[95:64];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        h_d     = h_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (row_start) begin
                    h_d     = h_mcu;
                    x_d     = '0;
                    state_d = (h_mcu == 8'd0) ? DONE : REQ_Y;
                end
            end
            REQ_Y, REQ_CB: begin
                if (granted_last) begin
                    state_d = (state_q == REQ_Y) ? REQ_CB : REQ_CR;
                    cnt_d   = '0;
                end else if (tmo_evt) begin
                    state_d = ROW_END;
                    cnt_d   = '0;
                end
            end
            REQ_CR: begin
                if (granted_last) begin
                    cnt_d = '0;
                    if (x_q == h_q - 8'd1) begin
                        state_d = ROW_END;
                    end else begin
                        x_d     = x_q + 8'd1;
                        state_d = REQ_Y;
                    end
                end else if (tmo_evt) begin
                    state_d = ROW_END;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            h_q        <= '0;
            cnt_q      <= '0;
            ce_req_q   <= '0;
            busy_q     <= 1'b0;
            row_done_q <= 1'b0;
            out_len_q  <= '0;
            out_data_q <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            h_q        <= h_d;
            cnt_q      <= cnt_d;
            ce_req_q   <= req_onehot(state_d);
            busy_q     <= (state_d != IDLE);
            row_done_q <= (state_d == DONE);
            out_len_q  <= sel_len;
            out_data_q <= sel_data;
            err_q      <= (err_q & ~{3{err_clr}}) | {tmo_evt, ovr_evt, coll_evt};
        end
    end

    assign ce_req   = ce_req_q;
    assign ce_x_mcu = x_q;
    assign out_len  = out_len_q;
    assign out_data = out_data_q;
    assign busy     = busy_q;
    assign row_done = row_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ecs_scheduler.sv
// Scoreboard bench for ecs_scheduler: expected packer words are queued as they are driven
// and matched (value and 1-cycle latency) when they appear on out_len/out_data.
`timescale 1ns/1ps
module tb_ecs_scheduler;

    logic        clk;
    logic        rst;
    logic        row_start;
    logic [7:0]  h_mcu;
    logic [2:0]  ce_req;
    logic [7:0]  ce_x_mcu;
    logic [17:0] ce_len;
    logic [95:0] ce_data;
    logic [2:0]  ce_last;
    logic [5:0]  out_len;
    logic [31:0] out_data;
    logic        busy;
    logic        row_done;
    logic        err_clr;
    logic [2:0]  err;

    typedef struct {
        logic [5:0]  len;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    ecs_scheduler #(.GAP_CYCLES(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .row_start(row_start), .h_mcu(h_mcu),
        .ce_req(ce_req), .ce_x_mcu(ce_x_mcu), .ce_len(ce_len), .ce_data(ce_data),
        .ce_last(ce_last), .out_len(out_len), .out_data(out_data), .busy(busy),
        .row_done(row_done), .err_clr(err_clr), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (out_len !== 6'd0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL out_word: got len=%0d data=%h at cyc %0d, required no word", out_len, out_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (out_len !== mon_e.len || out_data !== mon_e.data || cyc != mon_e.cyc) begin
                        miscompares++;
                        $display("FAIL out_word: got len=%0d data=%h cyc=%0d, required len=%0d data=%h cyc=%0d",
                                 out_len, out_data, cyc, mon_e.len, mon_e.data, mon_e.cyc);
                    end
                end
            end else if (out_data !== 32'd0) begin
                vectors++;
                miscompares++;
                $display("FAIL out_idle_data: got %h with out_len=0, required 0", out_data);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ce();
        ce_len  = '0;
        ce_data = '0;
        ce_last = '0;
    endtask

    task automatic start_row(input logic [7:0] h);
        row_start = 1'b1;
        h_mcu     = h;
        tick();
        row_start = 1'b0;
        h_mcu     = 8'hAA;
    endtask

    task automatic drive_words(input int comp, input int n);
        for (int w = 0; w < n; w++) begin
            logic [5:0]  l;
            logic [31:0] d;
            l = 6'($urandom_range(32, 1));
            d = $urandom;
            if (l < 6'd32) d = d & ((32'd1 << l) - 32'd1);
            clear_ce();
            ce_len[comp*6 +: 6]   = l;
            ce_data[comp*32 +: 32] = d;
            ce_last[comp]         = (w == n - 1);
            exp_q.push_back('{l, d, cyc + 1});
            tick();
        end
        clear_ce();
    endtask

    task automatic wait_done(input int bound, output int n);
        n = -1;
        for (int i = 0; i < bound; i++) begin
            if (row_done === 1'b1) begin
                n = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({ce_req, ce_x_mcu, out_len, out_data, busy, row_done, err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got req=%b x=%0d len=%0d data=%h busy=%b done=%b err=%b, required all 0",
                     ce_req, ce_x_mcu, out_len, out_data, busy, row_done, err);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || ce_req !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_release_idle: got busy=%b req=%b, required 0/000", busy, ce_req);
        end
    endtask

    task automatic test_row();
        logic [2:0] oh;
        start_row(8'd2);
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < 3; c++) begin
                oh = 3'b001 << c;
                vectors++;
                if (ce_req !== oh || ce_x_mcu !== 8'(m)) begin
                    miscompares++;
                    $display("FAIL row_grant: got req=%b x=%0d, required req=%b x=%0d", ce_req, ce_x_mcu, oh, m);
                end
                drive_words(c, 3);
            end
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (row_done !== 1'b0 || ce_req !== 3'b000 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL row_gap[%0d]: got done=%b req=%b busy=%b, required 0/000/1", i, row_done, ce_req, busy);
            end
            tick();
        end
        vectors++;
        if (row_done !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL row_done_pulse: got done=%b busy=%b, required 1/1", row_done, busy);
        end
        tick();
        vectors++;
        if (row_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL row_back_idle: got done=%b busy=%b, required 0/0", row_done, busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL row_words_left: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_zero_row();
        start_row(8'd0);
        vectors++;
        if (busy !== 1'b1 || row_done !== 1'b1 || ce_req !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_done: got busy=%b done=%b req=%b, required 1/1/000", busy, row_done, ce_req);
        end
        row_start = 1'b1;
        h_mcu     = 8'd5;
        tick();
        row_start = 1'b0;
        vectors++;
        if (busy !== 1'b0 || row_done !== 1'b0 || ce_req !== 3'b000 || err !== 3'b010) begin
            miscompares++;
            $display("FAIL zero_overrun_in_done: got busy=%b done=%b req=%b err=%b, required 0/0/000/010",
                     busy, row_done, ce_req, err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++;
        if (err !== 3'b000) begin
            miscompares++;
            $display("FAIL zero_err_clr: got err=%b, required 000", err);
        end
    endtask

    task automatic test_collision();
        int n;
        start_row(8'd1);
        vectors++;
        if (ce_req !== 3'b001) begin
            miscompares++;
            $display("FAIL coll_grant_y: got req=%b, required 001", ce_req);
        end
        ce_len[5:0]    = 6'd4;
        ce_data[31:0]  = 32'hA;
        ce_len[11:6]   = 6'd5;
        ce_data[63:32] = 32'h1F;
        exp_q.push_back('{6'd4, 32'hA, cyc + 1});
        tick();
        clear_ce();
        vectors++;
        if (err !== 3'b001 || ce_req !== 3'b001) begin
            miscompares++;
            $display("FAIL coll_flag: got err=%b req=%b, required 001/001", err, ce_req);
        end
        drive_words(0, 2);
        vectors++;
        if (ce_req !== 3'b010 || err !== 3'b001) begin
            miscompares++;
            $display("FAIL coll_y_continues: got req=%b err=%b, required 010/001", ce_req, err);
        end
        drive_words(1, 1);
        drive_words(2, 1);
        wait_done(20, n);
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL coll_row_done: got row_done after %0d cycles, required 8", n);
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_overrun();
        int n;
        logic [2:0] oh;
        start_row(8'd3);
        drive_words(0, 1);
        row_start = 1'b1;
        h_mcu     = 8'd7;
        tick();
        row_start = 1'b0;
        vectors++;
        if (err !== 3'b010 || ce_req !== 3'b010) begin
            miscompares++;
            $display("FAIL ovr_flag: got err=%b req=%b, required 010/010", err, ce_req);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        vectors++;
        if (err !== 3'b000) begin
            miscompares++;
            $display("FAIL ovr_err_clr: got err=%b, required 000", err);
        end
        err_clr       = 1'b1;
        ce_len[17:12] = 6'd3;
        tick();
        err_clr = 1'b0;
        clear_ce();
        vectors++;
        if (err !== 3'b001 || ce_req !== 3'b010) begin
            miscompares++;
            $display("FAIL ovr_set_beats_clr: got err=%b req=%b, required 001/010", err, ce_req);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        drive_words(1, 1);
        drive_words(2, 1);
        for (int m = 1; m < 3; m++) begin
            for (int c = 0; c < 3; c++) begin
                oh = 3'b001 << c;
                vectors++;
                if (ce_req !== oh || ce_x_mcu !== 8'(m)) begin
                    miscompares++;
                    $display("FAIL ovr_grant: got req=%b x=%0d, required req=%b x=%0d", ce_req, ce_x_mcu, oh, m);
                end
                drive_words(c, 1);
            end
        end
        vectors++;
        if (ce_req !== 3'b000 || busy !== 1'b1 || ce_x_mcu !== 8'd2) begin
            miscompares++;
            $display("FAIL ovr_h_latched: got req=%b busy=%b x=%0d, required 000/1/2", ce_req, busy, ce_x_mcu);
        end
        wait_done(20, n);
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL ovr_row_done: got row_done after %0d cycles, required 8", n);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        start_row(8'd2);
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (ce_req !== 3'b001 || err !== 3'b000) begin
                miscompares++;
                $display("FAIL tmo_wait[%0d]: got req=%b err=%b, required 001/000", i, ce_req, err);
            end
            if (i < 4) begin
                ce_len[5:0]   = 6'(i + 1);
                ce_data[31:0] = 32'(i);
                exp_q.push_back('{6'(i + 1), 32'(i), cyc + 1});
            end
            tick();
            clear_ce();
        end
        vectors++;
        if (ce_req !== 3'b000 || err !== 3'b100 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_flag: got req=%b err=%b busy=%b, required 000/100/1", ce_req, err, busy);
        end
        wait_done(20, n);
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL tmo_row_done: got row_done after %0d cycles, required 8", n);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int bad;
        start_row(8'd2);
        drive_words(0, 1);
        drive_words(1, 1);
        drive_words(2, 1);
        drive_words(0, 1);
        drive_words(1, 1);
        ce_len[17:12]  = 6'd7;
        ce_data[95:64] = 32'h55;
        exp_q.push_back('{6'd7, 32'h55, cyc + 1});
        tick();
        clear_ce();
        vectors++;
        if (out_len !== 6'd7 || ce_x_mcu !== 8'd1) begin
            miscompares++;
            $display("FAIL rstmid_pre: got len=%0d x=%0d, required 7/1", out_len, ce_x_mcu);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if ({ce_req, ce_x_mcu, out_len, out_data, busy, row_done, err} !== '0) begin
            miscompares++;
            $display("FAIL rstmid_async: got req=%b x=%0d len=%0d data=%h busy=%b done=%b err=%b, required all 0",
                     ce_req, ce_x_mcu, out_len, out_data, busy, row_done, err);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || ce_req !== 3'b000) begin
            miscompares++;
            $display("FAIL rstmid_idle: got busy=%b req=%b, required 0/000", busy, ce_req);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (row_done !== 1'b0 || busy !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL rstmid_no_done: got %0d cycles with row_done/busy, required 0", bad);
        end
    endtask

    task automatic test_max_row();
        int bad;
        int n;
        logic [2:0] oh;
        bad = 0;
        start_row(8'd255);
        for (int m = 0; m < 255; m++) begin
            for (int c = 0; c < 3; c++) begin
                oh = 3'b001 << c;
                if (ce_req !== oh || ce_x_mcu !== 8'(m)) bad++;
                drive_words(c, 1);
            end
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL max_grants: got %0d bad grant/index cycles, required 0", bad);
        end
        vectors++;
        if (ce_req !== 3'b000 || ce_x_mcu !== 8'd254) begin
            miscompares++;
            $display("FAIL max_end: got req=%b x=%0d, required 000/254", ce_req, ce_x_mcu);
        end
        wait_done(20, n);
        vectors++;
        if (n != 8) begin
            miscompares++;
            $display("FAIL max_row_done: got row_done after %0d cycles, required 8", n);
        end
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        row_start = 1'b0;
        h_mcu     = 8'd0;
        err_clr   = 1'b0;
        clear_ce();
        test_reset();
        test_row();
        test_zero_row();
        test_collision();
        test_overrun();
        test_timeout();
        test_reset_mid();
        test_max_row();
        tick();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL words_left: got %0d pending words, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
